// File: rtl/param_down_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : param_down_counter_pkg
//  Description : Shared FSM state encoding and default widths for the
//                parametrised down counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package param_down_counter_pkg;

  // Default widths: count/load, decrement step, terminal-event counter
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_STEP_W = 4;
  localparam int DEF_TCNT_W = 4;

  // Counter control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : param_down_counter_pkg
`default_nettype wire

// File: rtl/param_down_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : param_down_counter_if
//  Description : Control/status bundle of the down counter. The master side
//                loads and steps the counter, the slave side is the counter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface param_down_counter_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4,
  parameter int TCNT_W = 4
);

  logic [WIDTH-1:0]  in;
  logic              latch;
  logic              dec;
  logic [STEP_W-1:0] step;
  logic              divide_by_two;
  logic              auto_reload;
  logic [WIDTH-1:0]  count;
  logic              zero;
  logic              tc_pulse;
  logic              busy;
  logic [TCNT_W-1:0] tc_count;

  modport master (
    output in, latch, dec, step, divide_by_two, auto_reload,
    input  count, zero, tc_pulse, busy, tc_count
  );

  modport slave (
    input  in, latch, dec, step, divide_by_two, auto_reload,
    output count, zero, tc_pulse, busy, tc_count
  );

endinterface : param_down_counter_if
`default_nettype wire

// File: rtl/param_down_counter_dcnt_next.sv
`default_nettype none
// ============================================================================
//  Module      : param_down_counter_dcnt_next
//  Description : Next-value datapath (dcnt_next): saturating subtract of a
//                zero-extended step, logical divide-by-two, or hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_down_counter_dcnt_next #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  wire logic [WIDTH-1:0]  i_count,
  input  wire logic [STEP_W-1:0] i_step,
  input  wire logic              i_dec,
  input  wire logic              i_shift,
  output logic      [WIDTH-1:0]  o_next
);

  // Compare and subtract at a width that holds both operands, so a step
  // wider than the count can never wrap below zero.
  localparam int CW = WIDTH + STEP_W;

  logic [CW-1:0]    w_count_ext;
  logic [CW-1:0]    w_step_ext;
  logic [CW-1:0]    w_diff;
  logic [WIDTH-1:0] w_sub;

  assign w_count_ext = {{STEP_W{1'b0}}, i_count};
  assign w_step_ext  = {{WIDTH{1'b0}}, i_step};
  assign w_diff      = w_count_ext - w_step_ext;

  // Saturating subtract, then select dec > shift > hold
  always_comb begin
    w_sub  = (w_count_ext > w_step_ext) ? w_diff[WIDTH-1:0] : '0;
    o_next = i_count;
    if (i_dec) begin
      o_next = w_sub;
    end else if (i_shift) begin
      o_next = i_count >> 1;
    end
  end

endmodule : param_down_counter_dcnt_next
`default_nettype wire

// File: rtl/param_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : param_down_counter
//  Description : Parametrised down counter with programmable step, shift
//                mode, terminal-count pulse, auto-reload and a wrapping
//                count of terminal events.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_down_counter
  import param_down_counter_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W,
  parameter int TCNT_W = DEF_TCNT_W
) (
  input  wire logic              clock,
  input  wire logic              reset_n,
  param_down_counter_if.slave    bus
);

  state_e            state_q,    state_d;
  logic [WIDTH-1:0]  count_q,    count_d;
  logic [WIDTH-1:0]  reload_q,   reload_d;
  logic              tc_pulse_q, tc_pulse_d;
  logic [TCNT_W-1:0] tc_count_q, tc_count_d;
  logic [WIDTH-1:0]  w_next;

  param_down_counter_dcnt_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_dcnt_next (
    .i_count (count_q),
    .i_step  (bus.step),
    .i_dec   (bus.dec),
    .i_shift (bus.divide_by_two),
    .o_next  (w_next)
  );

  // Next-state and register update: latch > dec > divide_by_two > hold
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    tc_pulse_d = 1'b0;
    tc_count_d = tc_count_q;
    if (bus.latch) begin
      // A load always wins and never counts as a terminal event
      count_d  = bus.in;
      reload_d = bus.in;
      state_d  = (bus.in != '0) ? ST_RUN : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (bus.dec || bus.divide_by_two) begin
            count_d = w_next;
            if (w_next == '0) begin
              state_d    = ST_DONE;
              tc_pulse_d = 1'b1;
              tc_count_d = tc_count_q + TCNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          // A zero reload would re-terminate instantly, so it parks here
          if (bus.auto_reload && (reload_q != '0)) begin
            count_d = reload_q;
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      tc_pulse_q <= 1'b0;
      tc_count_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      tc_pulse_q <= tc_pulse_d;
      tc_count_q <= tc_count_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.zero     = (count_q == '0);
  assign bus.tc_pulse = tc_pulse_q;
  assign bus.busy     = (state_q == ST_RUN);
  assign bus.tc_count = tc_count_q;

endmodule : param_down_counter
`default_nettype wire
